// File: rtl/comp_gain_loader.sv
// rtl/comp_gain_loader.sv - compressor gain table load sequencer (shadow RAM -> serial SRL)
// Optional macro COMP_LOAD_MUTE_EN: drive mute while the table is being rewritten.
module comp_gain_loader #(
  parameter int ENTRIES  = 128,
  parameter int AW       = 7,
  parameter int DW       = 8,
  parameter int FLAT_VAL = 16,
  parameter int LOAD_DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] hwa,
  input  logic [DW-1:0] hwd,
  input  logic          hwe,
  input  logic          cmd_load,
  input  logic          cmd_flat,
  output logic [DW-1:0] cin,
  output logic          cwe,
  output logic          busy,
  output logic          done,
  output logic          mute,
  output logic          werr
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  localparam logic [4:0]    DIV_LAST = 5'(LOAD_DIV - 1);
  localparam logic [AW-1:0] PTR_TOP  = AW'(ENTRIES - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] ram [ENTRIES];
  logic [DW-1:0] rdata;
  logic [DW-1:0] cin_q;
  logic [DW-1:0] src;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [4:0]    div_cnt;
  logic          flat_mode;
  logic          accept;
  logic          tick;

  assign accept = (state == IDLE) && (cmd_load || cmd_flat);
  assign tick   = (state == STREAM) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_load || cmd_flat) state_nxt = PRIME;
      PRIME:   state_nxt = STREAM;
      STREAM:  if (tick && (ptr == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    cwe  = 1'b0;
    case (state)
      PRIME:   busy = 1'b1;
      STREAM:  begin busy = 1'b1; cwe = tick; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef COMP_LOAD_MUTE_EN
  always_comb mute = (state != IDLE);
`else
  assign mute = 1'b0;
`endif

  // The RAM is addressed with the next pointer so rdata always tracks ram[ptr].
  always_comb begin
    ptr_nxt = ptr;
    if (accept)    ptr_nxt = PTR_TOP;
    else if (tick) ptr_nxt = ptr - AW'(1);
  end

  always_ff @(posedge clk) begin
    if (hwe && (state == IDLE)) ram[hwa] <= hwd;
    rdata <= ram[ptr_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      div_cnt   <= '0;
      flat_mode <= 1'b0;
      cin_q     <= '0;
      werr      <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      if (state != STREAM || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 5'd1;
      if (accept) flat_mode <= cmd_flat;
      if (cwe)    cin_q <= src;
      if (accept)
        werr <= 1'b0;
      else if ((state != IDLE) && (hwe || cmd_load || cmd_flat))
        werr <= 1'b1;
    end
  end

  assign src = flat_mode ? DW'(FLAT_VAL) : rdata;
  // cin follows the source during a pulse and holds the last shifted value otherwise.
  assign cin = cwe ? src : cin_q;

endmodule

// File: tb/tb_comp_gain_loader.sv
// tb/tb_comp_gain_loader.sv - directed bench for comp_gain_loader (LOAD_DIV=1 and LOAD_DIV=4 instances)
module tb_comp_gain_loader;

`ifdef COMP_LOAD_MUTE_EN
  localparam bit MUTE_ON = 1'b1;
`else
  localparam bit MUTE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [6:0] hwa;
  logic [7:0] hwd;
  logic       hwe;
  logic       cmd_load1, cmd_flat1, cmd_load4, cmd_flat4;
  logic [7:0] cin1, cin4;
  logic       cwe1, busy1, done1, mute1, werr1;
  logic       cwe4, busy4, done4, mute4, werr4;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] model [128];
  logic [7:0] srl   [128];

  always #5 clk = ~clk;

  comp_gain_loader #(.LOAD_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .hwa(hwa), .hwd(hwd), .hwe(hwe),
    .cmd_load(cmd_load1), .cmd_flat(cmd_flat1),
    .cin(cin1), .cwe(cwe1), .busy(busy1), .done(done1), .mute(mute1), .werr(werr1)
  );

  comp_gain_loader #(.LOAD_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .hwa(hwa), .hwd(hwd), .hwe(hwe),
    .cmd_load(cmd_load4), .cmd_flat(cmd_flat4),
    .cin(cin4), .cwe(cwe4), .busy(busy4), .done(done4), .mute(mute4), .werr(werr4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic write_all(input int mul, input int add);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      hwe = 1'b1; hwa = 7'(i); hwd = 8'(i * mul + add);
      model[i] = 8'(i * mul + add);
    end
    @(posedge clk); #1;
    hwe = 1'b0;
  endtask

  // Command to dut1 at cycle 0; optional same-cycle write to entry 127 and mid-stream intrusion at cycle 50.
  task automatic run1(input bit flat, input bit load, input bit same_wr, input logic [7:0] wdat, input bit inj);
    int         npulse;
    logic [7:0] exp;
    npulse = 0;
    @(posedge clk); #1;
    cmd_flat1 = flat; cmd_load1 = load;
    if (same_wr) begin hwe = 1'b1; hwa = 7'd127; hwd = wdat; model[127] = wdat; end
    @(negedge clk);
    check("c0_busy", busy1, 0);
    check("c0_cwe", cwe1, 0);
    @(posedge clk); #1;
    cmd_flat1 = 1'b0; cmd_load1 = 1'b0; hwe = 1'b0;
    for (int c = 1; c <= 132; c++) begin
      @(negedge clk);
      check("busy", busy1, (c <= 129));
      check("cwe", cwe1, (c >= 2 && c <= 129));
      check("done", done1, (c == 130));
      check("mute", mute1, MUTE_ON && c <= 130);
      check("werr", werr1, inj && c > 50);
      if (cwe1) begin
        exp = flat ? 8'd16 : model[129 - c];
        check("cin", cin1, exp);
        for (int k = 127; k > 0; k--) srl[k] = srl[k - 1];
        srl[0] = cin1;
        npulse++;
      end
      if (c == 131) check("cin_hold", cin1, flat ? 8'd16 : model[0]);
      if (inj && c == 50) begin
        hwe = 1'b1; hwa = 7'd5; hwd = 8'hAA; cmd_load1 = 1'b1;
      end else if (inj && c == 51) begin
        hwe = 1'b0; cmd_load1 = 1'b0;
      end
    end
    check("npulse", npulse, 128);
    for (int a = 0; a < 128; a++) check("srl", srl[a], flat ? 8'd16 : model[a]);
  endtask

  // Flat command to dut4; abort_at > 0 asserts rst4 during that pulse.
  task automatic run4(input int abort_at);
    int np, first, prev, done_c;
    np = 0; first = 0; prev = 0; done_c = 0;
    @(posedge clk); #1; cmd_flat4 = 1'b1;
    @(posedge clk); #1; cmd_flat4 = 1'b0;
    for (int c = 1; c <= 520; c++) begin
      @(negedge clk);
      if (cwe4) begin
        np++;
        if (np == 1) first = c;
        else check("d4_gap", c - prev, 4);
        prev = c;
        check("d4_cin", cin4, 16);
      end
      if (done4) done_c = c;
      if (abort_at != 0 && np == abort_at) begin
        check("d4_mute_mid", mute4, MUTE_ON);
        check("d4_busy_mid", busy4, 1);
        rst4 = 1'b1;
        #1;
        check("d4_abort_cwe", cwe4, 0);
        check("d4_abort_busy", busy4, 0);
        check("d4_abort_mute", mute4, 0);
        check("d4_abort_cin", cin4, 0);
        break;
      end
    end
    if (abort_at == 0) begin
      check("d4_npulse", np, 128);
      check("d4_first", first, 5);
      check("d4_done_cycle", done_c, 514);
      check("d4_busy_end", busy4, 0);
    end else begin
      @(posedge clk); #1; rst4 = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("d4_idle_busy", busy4, 0);
        check("d4_idle_cwe", cwe4, 0);
        check("d4_idle_done", done4, 0);
      end
    end
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    hwa = '0; hwd = '0; hwe = 1'b0;
    cmd_load1 = 1'b0; cmd_flat1 = 1'b0; cmd_load4 = 1'b0; cmd_flat4 = 1'b0;
    for (int k = 0; k < 128; k++) begin srl[k] = 8'h00; model[k] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cin", cin1, 0);
    check("rst_cwe", cwe1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_mute", mute1, 0);
    check("rst_werr", werr1, 0);
    check("rst4_busy", busy4, 0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst4 = 1'b0;

    run1(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    write_all(1, 0);
    run1(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    write_all(3, 7);
    run1(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
    run1(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 8'h5E, 1'b1);
    run1(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    run1(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    run4(0);
    run4(60);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/comp_gain_loader.md
Name: comp_gain_loader

Overview:
- Configuration sequencer for the compressor gain table, a 128-entry x 8-bit serial-load SRL driven by a cin/cwe pair.
- The host writes entries at random into a local shadow RAM, then issues a commit. The FSM then streams all entries into the compressor in the order the SRL requires: highest-magnitude entry (index 127) first, index 0 last.
- A flat command loads every entry with unity gain (16 = 1.0 in 4.4 format) without touching the shadow RAM.

Parameters:
- ENTRIES, 128, number of gain table entries (power of two)
- AW, 7, address width, log2(ENTRIES)
- DW, 8, gain entry width (4.4 unsigned)
- FLAT_VAL, 16, entry value used by the flat command (unity gain)
- LOAD_DIV, 1, clocks per cwe pulse during streaming (1..16)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- hwa  in  AW  host write address, shadow index 0..ENTRIES-1 (0 = smallest magnitude)
- hwd  in  DW  host write data
- hwe  in  1  host write strobe, one entry per clock
- cmd_load  in  1  single-cycle pulse: stream shadow RAM to compressor
- cmd_flat  in  1  single-cycle pulse: stream FLAT_VAL to all entries
- cin  out  DW  compressor configuration data
- cwe  out  1  compressor configuration shift enable
- busy  out  1  high from the cycle after an accepted command until done
- done  out  1  one-clock pulse when the last entry has been shifted
- mute  out  1  request to gate compressor output valid while the table is inconsistent
- werr  out  1  sticky: a host write or command arrived while busy; cleared by reset or the next accepted command

Behaviour:
- Reset values: cin=0, cwe=0, busy=0, done=0, mute=0, werr=0, FSM=IDLE, counters=0. Shadow RAM contents are not reset.
- Shadow RAM:
  - Synchronous write when hwe=1 and FSM=IDLE.
  - Synchronous read, 1-clock latency.
  - hwe while busy: write discarded, werr set.
- FSM states: IDLE, PRIME, STREAM, DONE.
  - IDLE: cmd_flat or cmd_load accepted. If both in the same cycle, flat wins. Latch mode; set read pointer = ENTRIES-1; go to PRIME; clear werr.
  - PRIME: one cycle for the first RAM read; go to STREAM.
  - STREAM: every LOAD_DIV clocks, assert cwe for exactly one clock with cin = RAM data (load mode) or FLAT_VAL (flat mode), then decrement the pointer. After the pulse at pointer 0, go to DONE.
  - DONE: done=1 for one clock, busy=0 next cycle; return to IDLE.
- Commands while not IDLE are ignored and set werr.
- Exactly ENTRIES cwe pulses per command. No gaps when LOAD_DIV=1, so STREAM lasts ENTRIES clocks.
- Latency with LOAD_DIV=1:
  - cmd at cycle 0 gives busy=1 from cycle 1.
  - First cwe at cycle 2 carries index 127.
  - Last cwe at cycle 129 carries index 0.
  - done=1 at cycle 130.
- cin holds its last driven value when cwe=0. It is don't-care to the compressor.
- Pointer wrap: the decrement from 0 is never used, because the FSM leaves STREAM first.
- Reset mid-stream: immediate abort, outputs to reset values. The compressor table is then partially shifted and undefined until the next full command.
- A host write in the same cycle as an accepted command is performed, because the FSM is still IDLE. A commit issued one cycle after a write sees the new data.

Optional Feature:
- COMP_LOAD_MUTE_EN defined:
  - mute=1 from the cycle an accepted command leaves IDLE through the DONE cycle inclusive.
  - The compressor output gate suppresses ov during table rewrite.
- COMP_LOAD_MUTE_EN undefined:
  - mute is tied 0 and no mute logic is generated.
  - The audio path passes through a table rewrite with transitional gains.

Test Plan:
- Reset then cmd_flat, LOAD_DIV=1 -> 128 consecutive cwe pulses cycles 2..129, cin=16 each; done at cycle 130; busy 1..129; werr=0.
- Write shadow[i]=i for i=0..127, then cmd_load -> cin sequence 127,126,...,0 on cwe cycles; a model SRL128 read at address a returns a for all a.
- Assert cmd_load and cmd_flat in the same cycle -> flat stream (all 16); shadow RAM unchanged, verified by a later cmd_load replaying prior contents.
- During streaming, hwe with hwa=5, hwd=0xAA, plus a cmd_load pulse -> write and command ignored, werr=1; the following accepted command clears werr; shadow[5] keeps its old value.
- LOAD_DIV=4, cmd_flat -> cwe pulses every 4th clock, 128 pulses total, done about 2+512 cycles after command; rst asserted at pulse 60 -> cwe, busy and mute drop asynchronously, FSM=IDLE.
- With COMP_LOAD_MUTE_EN defined -> mute high exactly from cycle 1 through the done cycle; undefined -> mute constantly 0.
